// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared definitions for the SPI configuration register.
//   SPI_MODE0..3 : SPI mode encodings as {CPOL, CPHA}
//   cnt_width()  : width of a bit counter that must reach WIDTH+1
package spi_cfg_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // The counter saturates at width+1 so an overrun frame is distinguishable
  // from an exact-length one.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/spi_config_register_sync.sv
// spi_sync_edge: multi-flop synchroniser with edge detection.
//   clk, rst  : system clock, synchronous active-high reset
//   din       : asynchronous input
//   level     : synchronised level (STAGES flops after din)
//   rise/fall : single-cycle pulses when level changes, from one extra flop
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_config_register.sv
// spi_config_register: SPI slave shift register with a shadow copy that only
// updates on a complete frame. The previous configuration is read back on
// spi_sdo while the new one shifts in.
//   clk, rst    : system clock, synchronous active-high reset
//   spi_cs_b    : chip select (active low, asynchronous)
//   spi_sclk    : SPI clock (asynchronous)
//   spi_sdi     : serial data in, MSB first
//   spi_sdo     : serial data out, registered
//   spi_bits    : shadow register (applied configuration)
//   cfg_update  : one-cycle pulse when spi_bits is loaded
//   frame_err   : one-cycle pulse when a frame ended with bit count != WIDTH
//   busy        : synchronised chip select is active
// There is no handshake: spi_bits is valid at all times and changes only in
// the cycle cfg_update is high.
module spi_config_register
  import spi_cfg_pkg::*;
#(
  parameter int               WIDTH       = 1280,
  parameter int               CPOL        = 0,
  parameter int               CPHA        = 0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_cs_b,
  input  logic             spi_sclk,
  input  logic             spi_sdi,
  output logic             spi_sdo,
  output logic [WIDTH-1:0] spi_bits,
  output logic             cfg_update,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);
  localparam logic [1:0]     MODE     = {CPOL != 0, CPHA != 0};
  localparam bit             IDLE_HIGH       = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
  localparam bit             SAMPLE_TRAILING = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic sync_unused;

  // All three pins share the same synchroniser depth so sdi_s stays aligned
  // with the sclk edges it is sampled on.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(IDLE_HIGH)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi_cs_b),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .rst(rst), .din(spi_sdi),
    .level(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign sync_unused = sclk_s ^ sdi_rise ^ sdi_fall;

  // Leading edge leaves the idle level, trailing edge returns to it.
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = IDLE_HIGH ? sclk_fall : sclk_rise;
  assign trail_edge  = IDLE_HIGH ? sclk_rise : sclk_fall;
  assign sample_edge = SAMPLE_TRAILING ? trail_edge : lead_edge;
  assign shift_edge  = SAMPLE_TRAILING ? lead_edge : trail_edge;

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_sdo    <= 1'b0;
      spi_bits   <= RESET_VALUE;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      if (cs_fall) begin
        // Frame start: preload readback data; any SCLK edge this cycle is dropped.
        shift_reg <= spi_bits;
        bit_cnt   <= '0;
        busy      <= 1'b1;
        if (!SAMPLE_TRAILING) spi_sdo <= spi_bits[WIDTH-1];
      end else if (cs_rise) begin
        busy    <= 1'b0;
        spi_sdo <= 1'b0;
        if (bit_cnt == CNT_FULL) begin
          spi_bits   <= shift_reg;
          cfg_update <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end else if (!cs_s) begin
        // Sample and shift-out edges are opposite SCLK edges, never coincident.
        if (sample_edge) begin
          shift_reg <= {shift_reg[WIDTH-2:0], sdi_s};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
        end
        if (shift_edge) spi_sdo <= shift_reg[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/spi_config_register.md
Name: spi_config_register

Overview:
Parametrised successor to the fixed 1280-bit FRIDA SPI shift register. Adds:
- configurable width, CPOL/CPHA mode and synchroniser depth;
- a shadow register that only updates when a frame is complete;
- readback of the current configuration during each write frame;
- frame-error detection.

It sits between the external SPI pins and the ADC control bits, running on the system clock.

Parameters:
WIDTH, 1280, shift/shadow register length in bits (>=8)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge and shift out on trailing edge; 1 = shift out on leading edge and sample on trailing edge
SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_cs_b and spi_sdi (>=2)
RESET_VALUE, {WIDTH{1'b0}}, shadow register value after reset

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
spi_cs_b  in  1  chip select, active low, asynchronous to clk
spi_sclk  in  1  SPI clock, asynchronous to clk
spi_sdi  in  1  serial data in (MOSI), MSB first
spi_sdo  out  1  serial data out (MISO), registered
spi_bits  out  WIDTH  shadow register (applied configuration)
cfg_update  out  1  one-cycle pulse: shadow register loaded
frame_err  out  1  one-cycle pulse: frame ended with bit count != WIDTH
busy  out  1  high while synchronised CS is active

Behaviour:
Reset and synchronisation:
- Reset values: spi_sdo=0, spi_bits=RESET_VALUE, cfg_update=0, frame_err=0, busy=0, shift_reg=0, bit_cnt=0.
- During reset, sync chains take idle values (cs=1, sclk=CPOL, sdi=0).
- All three inputs pass through SYNC_STAGES flops (cs_s, sclk_s, sdi_s), so sdi stays aligned with sclk.
- One further flop on cs_s and on sclk_s provides edge detection.
- Leading edge: sclk_s leaves CPOL. Trailing edge: sclk_s returns to CPOL.

Frame start (cs_s falls):
- shift_reg <= spi_bits; bit_cnt <= 0; busy <= 1.
- If CPHA=0: spi_sdo <= spi_bits[WIDTH-1] in the same cycle.
- An SCLK edge in this same cycle is ignored.

Sample edge (leading if CPHA=0, trailing if CPHA=1), only while cs_s=0:
- shift_reg <= {shift_reg[WIDTH-2:0], sdi_s}.
- bit_cnt increments and saturates at WIDTH+1; width is $clog2(WIDTH+2).

Shift-out edge (trailing if CPHA=0, leading if CPHA=1), only while cs_s=0:
- spi_sdo <= shift_reg[WIDTH-1].
- Result: the previous spi_bits are read back MSB first while new data shifts in.

Frame end (cs_s rises):
- busy <= 0; spi_sdo <= 0.
- If bit_cnt==WIDTH: spi_bits <= shift_reg and cfg_update=1 for one cycle.
- Otherwise (short frame, or overrun at WIDTH+1): frame_err=1 for one cycle; spi_bits unchanged.
- An SCLK edge in the same cycle is ignored, because cs_s=1 gates it.

Idle and timing:
- While cs_s=1, SCLK edges are ignored and shift_reg holds.
- Latency: an SCLK pin edge affects shift_reg/spi_sdo SYNC_STAGES+1 cycles later; cfg_update follows the CS pin rise by SYNC_STAGES+1 cycles.
- Constraint: SCLK high and low phases, and CS setup/hold to SCLK, each >= SYNC_STAGES+2 clk periods; faster SCLK is unsupported.

Reset mid-frame:
- Frame is aborted; spi_bits returns to RESET_VALUE.
- If CS is still low after reset, cs_s falls from its reset value 1, so a new frame starts.
- Bits clocked before that restart are lost; the frame then ends with frame_err unless exactly WIDTH further bits arrive.

cfg_update and frame_err are never high in the same cycle.

Decomposition:
- Package spi_cfg_pkg: mode constants (SPI_MODE0..3 as {CPOL,CPHA}) and the function cnt_width(WIDTH)=$clog2(WIDTH+2).
- Sub-module spi_sync_edge (parameter STAGES, RESET_VAL; outputs level, rise, fall). Instantiated for sclk and cs; sdi uses its level output only.
- Top level holds the shift/shadow registers, counter and frame control.

Test Plan:
- Mode 0, WIDTH=16, RESET_VALUE=16'hA5C3: shift in 16'h1234 -> spi_sdo bits read 0xA5C3 MSB first; spi_bits=16'h1234; one cfg_update pulse; frame_err never high.
- Modes 1/2/3 with the same data -> identical spi_bits and readback; sampling on the correct SCLK edge, checked with SDI changing at the opposite edge.
- 15-bit frame, then a 17-bit frame -> frame_err pulse each time; spi_bits unchanged from the previous value; no cfg_update.
- SCLK toggled 20 times with CS high -> no change to shift_reg, spi_bits or spi_sdo; busy=0.
- rst asserted after 8 of 16 bits with CS held low, then 16 more bits and CS rise -> spi_bits=RESET_VALUE during reset; a new frame starts; spi_bits=new data; one cfg_update.
- Two back-to-back 1280-bit frames (default WIDTH), CS high for SYNC_STAGES+2 cycles between them -> second frame reads back first frame's data; two cfg_update pulses.
